// File: rtl/rv32i_exec_mem_unit_pkg.sv
// Shared constants for the rv32i execute/memory slice: opcodes, ALU operations,
// immediate formats, write-back sources and the branch-condition selector.
package rv32i_exec_mem_unit_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLL   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_SLTU  = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic [1:0] {
        BR_NONE,
        BR_ZERO,
        BR_NONZERO,
        BR_ALWAYS
    } br_cond_e;

    // R- and I-type share the func3 map; only R-type lets func7[5] turn ADD into SUB.
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt, input logic allow_sub);
        alu_op_e op;
        case (f3)
            3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_exec_mem_unit_alu.sv
// Combinational 32-bit ALU with zero flag; shifts use b[4:0].
module rv32i_exec_mem_unit_alu
    import rv32i_exec_mem_unit_pkg::*;
(
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLL:   result = a << b[4:0];
            ALU_SRL:   result = a >> b[4:0];
            ALU_SRA:   result = $signed(a) >>> b[4:0];
            ALU_SLT:   result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/rv32i_exec_mem_unit_bram32.sv
// Word-addressed data memory: synchronous write, asynchronous read, plus an
// always-on read-only debug port. Byte-address bits [1:0] are ignored.
module rv32i_exec_mem_unit_bram32 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH) + 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    w_addr,
    input  logic [WIDTH-1:0] w_dat,
    input  logic             r_en,
    input  logic [AW-1:0]    r_addr,
    output logic [WIDTH-1:0] r_dat,
    input  logic [AW-1:0]    debug_addr,
    output logic [WIDTH-1:0] debug_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_addr[AW-1:2]] <= w_dat;
        end
    end

    assign r_dat      = r_en ? mem[r_addr[AW-1:2]] : '0;
    assign debug_data = mem[debug_addr[AW-1:2]];

    logic unused_byte_bits;
    assign unused_byte_bits = ^{w_addr[1:0], r_addr[1:0], debug_addr[1:0]};

endmodule

// File: rtl/rv32i_exec_mem_unit.sv
// Execute + memory slice of the single-cycle rv32i core: control decode,
// ALU and data BRAM whose write port is shared with an initialisation path.
module rv32i_exec_mem_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            func3,
    input  logic [6:0]            func7,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  init_done,
    input  logic [9:0]            init_w_addr,
    input  logic [DATA_WIDTH-1:0] init_w_dat,
    input  logic                  init_w_enb,
    input  logic [9:0]            debug_addr,
    output logic                  branch,
    output logic [2:0]            imm_src,
    output logic [3:0]            alu_ctrl,
    output logic                  alu_src,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_2_reg,
    output logic [1:0]            wrt_back_src,
    output logic [DATA_WIDTH-1:0] alu_results,
    output logic                  alu_zero,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] debug_data
);
    import rv32i_exec_mem_unit_pkg::*;

    alu_op_e  alu_op;
    br_cond_e br_cond;
    logic     rw_dec, mr_dec, mw_dec, m2r_dec, branch_taken;

    always_comb begin
        alu_op       = ALU_ADD;
        imm_src      = IMM_I;
        alu_src      = 1'b0;
        rw_dec       = 1'b0;
        mr_dec       = 1'b0;
        mw_dec       = 1'b0;
        m2r_dec      = 1'b0;
        wrt_back_src = WB_ALU;
        br_cond      = BR_NONE;
        case (opcode)
            OP_R: begin
                alu_op = arith_op(func3, func7[5], 1'b1);
                rw_dec = 1'b1;
            end
            OP_I: begin
                alu_op  = arith_op(func3, func7[5], 1'b0);
                alu_src = 1'b1;
                rw_dec  = 1'b1;
            end
            OP_LOAD: begin
                if (func3 == 3'b010) begin
                    alu_src      = 1'b1;
                    mr_dec       = 1'b1;
                    m2r_dec      = 1'b1;
                    rw_dec       = 1'b1;
                    wrt_back_src = WB_MEM;
                end
            end
            OP_STORE: begin
                if (func3 == 3'b010) begin
                    alu_src = 1'b1;
                    imm_src = IMM_S;
                    mw_dec  = 1'b1;
                end
            end
            OP_BRANCH: begin
                // Signed/unsigned compares reduce to SLT/SLTU, so "less than" is a non-zero result.
                case (func3)
                    3'b000: begin imm_src = IMM_B; alu_op = ALU_SUB;  br_cond = BR_ZERO;    end
                    3'b001: begin imm_src = IMM_B; alu_op = ALU_SUB;  br_cond = BR_NONZERO; end
                    3'b100: begin imm_src = IMM_B; alu_op = ALU_SLT;  br_cond = BR_NONZERO; end
                    3'b101: begin imm_src = IMM_B; alu_op = ALU_SLT;  br_cond = BR_ZERO;    end
                    3'b110: begin imm_src = IMM_B; alu_op = ALU_SLTU; br_cond = BR_NONZERO; end
                    3'b111: begin imm_src = IMM_B; alu_op = ALU_SLTU; br_cond = BR_ZERO;    end
                    default: ;
                endcase
            end
            OP_LUI: begin
                alu_op  = ALU_PASSB;
                alu_src = 1'b1;
                imm_src = IMM_U;
                rw_dec  = 1'b1;
            end
            OP_JAL: begin
                br_cond      = BR_ALWAYS;
                imm_src      = IMM_J;
                rw_dec       = 1'b1;
                wrt_back_src = WB_PC4;
            end
            default: ;
        endcase
    end

    assign alu_ctrl = alu_op;

    rv32i_exec_mem_unit_alu u_alu (
        .op     (alu_ctrl),
        .a      (rs1),
        .b      (alu_src ? imm : rs2),
        .result (alu_results),
        .zero   (alu_zero)
    );

    always_comb begin
        case (br_cond)
            BR_ZERO:    branch_taken = alu_zero;
            BR_NONZERO: branch_taken = !alu_zero;
            BR_ALWAYS:  branch_taken = 1'b1;
            default:    branch_taken = 1'b0;
        endcase
    end

    // Reset holds every side-effecting control low; decode-only fields still follow the opcode.
    assign branch    = rst & branch_taken;
    assign reg_write = rst & rw_dec;
    assign mem_read  = rst & mr_dec;
    assign mem_write = rst & mw_dec;
    assign mem_2_reg = rst & m2r_dec;

    logic                  bram_we;
    logic [9:0]            bram_w_addr;
    logic [DATA_WIDTH-1:0] bram_w_dat;

    assign bram_we     = rst & (init_done ? mem_write : init_w_enb);
    assign bram_w_addr = init_done ? alu_results[9:0] : init_w_addr;
    assign bram_w_dat  = init_done ? rs2 : init_w_dat;

    rv32i_exec_mem_unit_bram32 #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH),
        .AW    (10)
    ) u_bram (
        .clk        (clk),
        .we         (bram_we),
        .w_addr     (bram_w_addr),
        .w_dat      (bram_w_dat),
        .r_en       (mem_read),
        .r_addr     (alu_results[9:0]),
        .r_dat      (mem_rdata),
        .debug_addr (debug_addr),
        .debug_data (debug_data)
    );

    logic unused_func7;
    assign unused_func7 = ^{func7[6], func7[4:0]};

endmodule

// File: tb/tb_rv32i_exec_mem_unit.sv
// Scoreboard bench for rv32i_exec_mem_unit: directed cases then random ones,
// each checked against an instruction-level reference model with a memory image.
module tb_rv32i_exec_mem_unit;

    typedef struct {
        logic        rst;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] rs1, rs2, imm;
        logic        init_done;
        logic [9:0]  init_w_addr;
        logic [31:0] init_w_dat;
        logic        init_w_enb;
        logic [9:0]  debug_addr;
    } stim_t;

    typedef struct {
        logic        branch, alu_src, reg_write, mem_read, mem_write, mem_2_reg, alu_zero;
        logic [2:0]  imm_src;
        logic [3:0]  alu_ctrl;
        logic [1:0]  wb;
        logic [31:0] res, rdata, ddata;
        logic        chk_ctrl, chk_res, chk_imm, chk_wb, chk_rdata, chk_debug;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  func3 = '0;
    logic [6:0]  func7 = '0;
    logic [31:0] rs1 = '0, rs2 = '0, imm = '0;
    logic        init_done = 1'b0;
    logic [9:0]  init_w_addr = '0;
    logic [31:0] init_w_dat = '0;
    logic        init_w_enb = 1'b0;
    logic [9:0]  debug_addr = '0;

    logic        branch, alu_src, reg_write, mem_read, mem_write, mem_2_reg, alu_zero;
    logic [2:0]  imm_src;
    logic [3:0]  alu_ctrl;
    logic [1:0]  wrt_back_src;
    logic [31:0] alu_results, mem_rdata, debug_data;

    rv32i_exec_mem_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
        .rs1(rs1), .rs2(rs2), .imm(imm), .init_done(init_done),
        .init_w_addr(init_w_addr), .init_w_dat(init_w_dat), .init_w_enb(init_w_enb),
        .debug_addr(debug_addr), .branch(branch), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
        .alu_src(alu_src), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_2_reg(mem_2_reg), .wrt_back_src(wrt_back_src), .alu_results(alu_results),
        .alu_zero(alu_zero), .mem_rdata(mem_rdata), .debug_data(debug_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_img [256];
    bit          mem_known [256];
    exp_t        exp_q[$];
    string       tag_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          txn_no = 0;

    // RV32I arithmetic semantics for one func3 (alt = func7[5] variant).
    function automatic void arith(input logic [2:0] f3, input logic alt, input logic [31:0] a,
                                  input logic [31:0] b, output logic [3:0] code, output logic [31:0] r);
        logic signed [31:0] sa;
        sa = a;
        case (f3)
            3'b000: begin code = alt ? 4'b0001 : 4'b0000; r = alt ? a - b : a + b; end
            3'b001: begin code = 4'b0101; r = a << b[4:0]; end
            3'b010: begin code = 4'b1000; r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
            3'b011: begin code = 4'b1001; r = (a < b) ? 32'd1 : 32'd0; end
            3'b100: begin code = 4'b0100; r = a ^ b; end
            3'b101: begin code = alt ? 4'b0111 : 4'b0110; r = alt ? 32'(sa >>> b[4:0]) : a >> b[4:0]; end
            3'b110: begin code = 4'b0011; r = a | b; end
            default: begin code = 4'b0010; r = a & b; end
        endcase
    endfunction

    function automatic exp_t model(stim_t s);
        exp_t e;
        logic [31:0] a, b;
        logic lt_s, lt_u;
        a = s.rs1; b = s.rs2;
        lt_s = $signed(a) < $signed(b);
        lt_u = a < b;
        e = '{branch: 0, alu_src: 0, reg_write: 0, mem_read: 0, mem_write: 0, mem_2_reg: 0,
              alu_zero: 0, imm_src: 3'b000, alu_ctrl: 4'b0000, wb: 2'b01, res: 0, rdata: 0,
              ddata: 0, chk_ctrl: 1, chk_res: 0, chk_imm: 1, chk_wb: 1, chk_rdata: 1, chk_debug: 0};
        case (s.opcode)
            7'b0110011: begin
                arith(s.func3, s.func7[5], a, b, e.alu_ctrl, e.res);
                e.reg_write = 1; e.chk_res = 1; e.chk_imm = 0;
            end
            7'b0010011: begin
                arith(s.func3, s.func7[5] && s.func3 == 3'b101, a, s.imm, e.alu_ctrl, e.res);
                e.alu_src = 1; e.reg_write = 1; e.chk_res = 1;
            end
            7'b0000011: if (s.func3 == 3'b010) begin
                e.res = a + s.imm; e.alu_src = 1; e.chk_res = 1;
                e.mem_read = 1; e.mem_2_reg = 1; e.reg_write = 1; e.wb = 2'b00;
            end
            7'b0100011: if (s.func3 == 3'b010) begin
                e.res = a + s.imm; e.alu_src = 1; e.chk_res = 1;
                e.imm_src = 3'b001; e.mem_write = 1; e.chk_wb = 0;
            end
            7'b1100011: if (s.func3 != 3'b010 && s.func3 != 3'b011) begin
                e.imm_src = 3'b010; e.chk_wb = 0; e.chk_res = 1;
                case (s.func3)
                    3'b000: begin e.alu_ctrl = 4'b0001; e.res = a - b; e.branch = (a == b); end
                    3'b001: begin e.alu_ctrl = 4'b0001; e.res = a - b; e.branch = (a != b); end
                    3'b100: begin e.alu_ctrl = 4'b1000; e.res = {31'd0, lt_s}; e.branch = lt_s; end
                    3'b101: begin e.alu_ctrl = 4'b1000; e.res = {31'd0, lt_s}; e.branch = !lt_s; end
                    3'b110: begin e.alu_ctrl = 4'b1001; e.res = {31'd0, lt_u}; e.branch = lt_u; end
                    default: begin e.alu_ctrl = 4'b1001; e.res = {31'd0, lt_u}; e.branch = !lt_u; end
                endcase
            end
            7'b0110111: begin
                e.alu_ctrl = 4'b1010; e.alu_src = 1; e.imm_src = 3'b011;
                e.reg_write = 1; e.res = s.imm; e.chk_res = 1;
            end
            7'b1101111: begin
                e.branch = 1; e.imm_src = 3'b100; e.reg_write = 1; e.wb = 2'b10; e.chk_ctrl = 0;
            end
            default: ;
        endcase
        e.alu_zero = (e.res == 0);
        if (!s.rst) begin
            e.branch = 0; e.reg_write = 0; e.mem_read = 0; e.mem_write = 0; e.mem_2_reg = 0;
        end
        if (e.mem_read) begin
            e.rdata = mem_img[e.res[9:2]];
            e.chk_rdata = mem_known[e.res[9:2]];
        end
        e.ddata = mem_img[s.debug_addr[9:2]];
        e.chk_debug = mem_known[s.debug_addr[9:2]];
        return e;
    endfunction

    task automatic issue(input stim_t s, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = s.rst; opcode = s.opcode; func3 = s.func3; func7 = s.func7;
        rs1 = s.rs1; rs2 = s.rs2; imm = s.imm; init_done = s.init_done;
        init_w_addr = s.init_w_addr; init_w_dat = s.init_w_dat; init_w_enb = s.init_w_enb;
        debug_addr = s.debug_addr;
        e = model(s);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        // The write lands on the coming edge, after this transaction is checked.
        if (s.rst && !s.init_done && s.init_w_enb) begin
            mem_img[s.init_w_addr[9:2]] = s.init_w_dat;
            mem_known[s.init_w_addr[9:2]] = 1;
        end else if (s.rst && s.init_done && e.mem_write) begin
            mem_img[e.res[9:2]] = s.rs2;
            mem_known[e.res[9:2]] = 1;
        end
    endtask

    task automatic chk(input string tag, input string field, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s.%s: got %h expected %h", tag, field, act, want);
        end
    endtask

    initial begin : monitor
        exp_t  e;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                chk(t, "branch", branch, e.branch);
                chk(t, "reg_write", reg_write, e.reg_write);
                chk(t, "mem_read", mem_read, e.mem_read);
                chk(t, "mem_write", mem_write, e.mem_write);
                chk(t, "mem_2_reg", mem_2_reg, e.mem_2_reg);
                if (e.chk_ctrl) chk(t, "alu_ctrl", alu_ctrl, e.alu_ctrl);
                if (e.chk_imm) chk(t, "imm_src", imm_src, e.imm_src);
                if (e.chk_wb) chk(t, "wrt_back_src", wrt_back_src, e.wb);
                if (e.chk_res) begin
                    chk(t, "alu_src", alu_src, e.alu_src);
                    chk(t, "alu_results", alu_results, e.res);
                    chk(t, "alu_zero", alu_zero, e.alu_zero);
                end
                if (e.chk_rdata) chk(t, "mem_rdata", mem_rdata, e.rdata);
                if (e.chk_debug) chk(t, "debug_data", debug_data, e.ddata);
                $display("txn %0d %s: op=%b f3=%b res=%h br=%b rdata=%h dbg[%h]=%h",
                         txn_no, t, opcode, func3, alu_results, branch, mem_rdata, debug_addr, debug_data);
                txn_no++;
            end
        end
    end

    function automatic stim_t base();
        stim_t s;
        s = '{rst: 1, opcode: 7'h00, func3: 0, func7: 0, rs1: 0, rs2: 0, imm: 0, init_done: 1,
              init_w_addr: 0, init_w_dat: 0, init_w_enb: 0, debug_addr: 0};
        return s;
    endfunction

    initial begin : stimulus
        stim_t s;
        int pick;
        foreach (mem_known[i]) mem_known[i] = 0;

        s = base(); s.rst = 0; s.opcode = 7'b0000011; s.func3 = 3'b010; s.imm = 32'd8;
        s.init_done = 0; s.init_w_enb = 1; s.init_w_dat = 32'hBAD0BAD0;
        issue(s, "reset_lw");

        for (int i = 0; i < 256; i++) begin
            s = base(); s.init_done = 0; s.init_w_enb = 1;
            s.init_w_addr = 10'(i * 4); s.init_w_dat = $urandom; s.debug_addr = 10'($urandom);
            issue(s, "fill");
        end

        for (int i = 0; i < 3; i++) begin
            s = base(); s.init_done = 0; s.init_w_enb = 1;
            s.init_w_addr = 10'(i * 4); s.init_w_dat = 32'(2 * i + 1);
            issue(s, "init135");
        end
        s = base(); s.rst = 0; s.init_done = 0; s.init_w_enb = 1; s.init_w_dat = 32'h99;
        issue(s, "init_in_reset");
        for (int i = 0; i < 3; i++) begin
            s = base(); s.debug_addr = 10'(i * 4);
            issue(s, "debug135");
        end

        s = base(); s.opcode = 7'b1100011; s.func3 = 3'b001; s.rs1 = 1; s.rs2 = 3; issue(s, "bne_1_3");
        s.rs1 = 5; s.rs2 = 5; issue(s, "bne_5_5");
        s.func3 = 3'b000; issue(s, "beq_5_5");

        s = base(); s.opcode = 7'b0000011; s.func3 = 3'b010; s.imm = 32'd8; issue(s, "lw_8");
        s = base(); s.opcode = 7'b0100011; s.func3 = 3'b010; s.imm = 32'hC; s.rs2 = 5; issue(s, "sw_c");
        s = base(); s.debug_addr = 10'hC; issue(s, "debug_c");

        s = base(); s.opcode = 7'b0110011; s.func7 = 7'h20; s.rs1 = 3; s.rs2 = 5; issue(s, "sub_3_5");
        s.func3 = 3'b101; s.rs1 = 32'h80000000; s.rs2 = 4; issue(s, "sra_4");
        s.func7 = 7'h00; s.func3 = 3'b011; s.rs1 = 1; s.rs2 = 32'hFFFFFFFF; issue(s, "sltu");

        s = base(); s.opcode = 7'b1101111; issue(s, "jal");
        s = base(); s.opcode = 7'h00; s.rs1 = 7; s.imm = 9; issue(s, "op_00");
        s = base(); s.rst = 0; s.opcode = 7'b0100011; s.func3 = 3'b010; s.imm = 32'h10; s.rs2 = 32'h77;
        issue(s, "sw_in_reset");
        s = base(); s.debug_addr = 10'h10; issue(s, "debug_10");

        for (int n = 0; n < 400; n++) begin
            s = base();
            pick = $urandom_range(0, 8);
            case (pick)
                0: s.opcode = 7'b0110011;
                1, 8: s.opcode = 7'b0010011;
                2: s.opcode = 7'b0000011;
                3: s.opcode = 7'b0100011;
                4: s.opcode = 7'b1100011;
                5: s.opcode = 7'b0110111;
                6: s.opcode = 7'b1101111;
                default: s.opcode = 7'($urandom);
            endcase
            s.func3 = 3'($urandom);
            if ((pick == 2 || pick == 3) && $urandom_range(0, 4) != 0) s.func3 = 3'b010;
            s.func7 = 7'($urandom);
            s.rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            s.rs2 = ($urandom_range(0, 3) == 0) ? s.rs1 : $urandom;
            s.imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1023)) : $urandom;
            s.rst = ($urandom_range(0, 19) != 0);
            s.init_done = ($urandom_range(0, 9) != 0);
            s.init_w_enb = 1'($urandom);
            s.init_w_addr = 10'($urandom);
            s.init_w_dat = $urandom;
            s.debug_addr = 10'($urandom);
            issue(s, "rand");
        end

        repeat (3) @(posedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
